// File: rtl/pong_engine_v2.sv
// Pong game core: steps the ball and paddle on step_en, scores left-wall rallies, start/end handshakes.
// Optional macro PONG_SERVE_RAND_EN: serve directions drawn from a free-running 8-bit LFSR.
module pong_engine_v2 #(
   parameter int COORD_W    = 8,
   parameter int BOARD_W    = 40,
   parameter int BOARD_H    = 16,
   parameter int VEL_X      = 1,
   parameter int VEL_Y      = 1,
   parameter int PADDLE_LEN = 2,
   parameter int PADDLE_VEL = 1,
   parameter int CNT_W      = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               game_start_valid,
   output logic               game_start_ready,
   input  logic               game_end_valid,
   output logic               game_end_ready,
   input  logic               step_en,
   input  logic [1:0]         paddle_control,
   output logic               result_valid,
   output logic               game_result,
   output logic [COORD_W-1:0] ball_x,
   output logic [COORD_W-1:0] ball_y,
   output logic [COORD_W-1:0] paddle_pos,
   output logic               ball_dir_x,
   output logic               ball_dir_y,
   output logic [CNT_W-1:0]   win_counter,
   output logic [CNT_W-1:0]   lose_counter
);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   localparam int W1 = COORD_W + 1;
   localparam logic [W1-1:0]      BW_C        = W1'(BOARD_W);
   localparam logic [W1-1:0]      BH_C        = W1'(BOARD_H);
   localparam logic [W1-1:0]      VX_C        = W1'(VEL_X);
   localparam logic [W1-1:0]      VY_C        = W1'(VEL_Y);
   localparam logic [W1-1:0]      PL_C        = W1'(PADDLE_LEN);
   localparam logic [W1-1:0]      PV_C        = W1'(PADDLE_VEL);
   localparam logic [W1-1:0]      X_RIGHT_K_C = W1'(2 * BOARD_W - VEL_X);
   localparam logic [W1-1:0]      Y_TOP_K_C   = W1'(2 * BOARD_H - VEL_Y);
   localparam logic [COORD_W-1:0] X_CTR_C     = COORD_W'(BOARD_W / 2);
   localparam logic [COORD_W-1:0] Y_CTR_C     = COORD_W'(BOARD_H / 2);
   localparam logic [COORD_W-1:0] PAD_RST_C   = COORD_W'(BOARD_H / 2 + PADDLE_LEN / 2);
   localparam logic [CNT_W-1:0]   CNT_MAX_C   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_ZERO_C  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX_C) ? v : v + CNT_ONE_C;
   endfunction

   state_t             state_r, state_s;
   logic [COORD_W-1:0] ball_x_r, ball_x_s, ball_y_r, ball_y_s, paddle_r, paddle_s;
   logic               dir_x_r, dir_x_s, dir_y_r, dir_y_s;
   logic [CNT_W-1:0]   win_r, win_s, lose_r, lose_s;
   logic               result_valid_r, result_valid_s, game_result_r, game_result_s;
   logic               serve_dx_s, serve_dy_s;

   // Widened copies so every intermediate sum or difference has headroom.
   logic [W1-1:0]      x_w_s, y_w_s, p_w_s, x_inc_s, y_inc_s, p_inc_s;
   logic               x_over_s, y_top_s, y_bot_s, rally_s, hit_s;
   logic [COORD_W-1:0] x_right_s, x_left_s, x_hit_s, y_up_s, y_dn_s, p_up_s, p_dn_s;

   assign x_w_s     = {1'b0, ball_x_r};
   assign y_w_s     = {1'b0, ball_y_r};
   assign p_w_s     = {1'b0, paddle_r};
   assign x_inc_s   = x_w_s + VX_C;
   assign y_inc_s   = y_w_s + VY_C;
   assign p_inc_s   = p_w_s + PV_C;
   assign x_over_s  = (x_inc_s > BW_C);
   assign y_top_s   = (y_inc_s > BH_C);
   assign y_bot_s   = (y_w_s < VY_C);
   assign rally_s   = dir_x_r && (x_w_s < VX_C);
   assign hit_s     = ((y_w_s + PL_C) >= p_w_s) && (y_w_s <= p_w_s);
   assign x_right_s = x_over_s ? COORD_W'(X_RIGHT_K_C - x_w_s) : COORD_W'(x_inc_s);
   assign x_left_s  = COORD_W'(x_w_s - VX_C);
   assign x_hit_s   = COORD_W'(VX_C - x_w_s);
   assign y_up_s    = y_top_s ? COORD_W'(Y_TOP_K_C - y_w_s) : COORD_W'(y_inc_s);
   assign y_dn_s    = y_bot_s ? COORD_W'(VY_C - y_w_s) : COORD_W'(y_w_s - VY_C);
   assign p_up_s    = (p_inc_s > BH_C) ? COORD_W'(BH_C) : COORD_W'(p_inc_s);
   assign p_dn_s    = (p_w_s < (PL_C + PV_C)) ? COORD_W'(PL_C) : COORD_W'(p_w_s - PV_C);

`ifdef PONG_SERVE_RAND_EN
   logic [7:0] lfsr_r;

   // Free-running Fibonacci LFSR, sampled at serve for the initial directions.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_r <= 8'hA5;
      end else begin
         lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
      end
   end

   assign serve_dx_s = lfsr_r[1];
   assign serve_dy_s = lfsr_r[0];
`else
   assign serve_dx_s = 1'b0;
   assign serve_dy_s = 1'b0;
`endif

   // Next-state and next-value logic for the game FSM and its datapath.
   always_comb begin
      state_s        = state_r;
      ball_x_s       = ball_x_r;
      ball_y_s       = ball_y_r;
      paddle_s       = paddle_r;
      dir_x_s        = dir_x_r;
      dir_y_s        = dir_y_r;
      win_s          = win_r;
      lose_s         = lose_r;
      result_valid_s = 1'b0;
      game_result_s  = game_result_r;
      case (state_r)
         ST_WAIT: begin
            if (game_start_valid) begin
               state_s  = ST_RUN;
               ball_x_s = X_CTR_C;
               ball_y_s = Y_CTR_C;
               paddle_s = PAD_RST_C;
               dir_x_s  = serve_dx_s;
               dir_y_s  = serve_dy_s;
               win_s    = CNT_ZERO_C;
               lose_s   = CNT_ZERO_C;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_RUN: begin
            if (game_end_valid) begin
               state_s = ST_WAIT;
            end else if (step_en && rally_s && !hit_s) begin
               state_s        = ST_RESULT;
               lose_s         = sat_inc(lose_r);
               result_valid_s = 1'b1;
               game_result_s  = 1'b0;
            end else if (step_en) begin
               if (!dir_x_r) begin
                  ball_x_s = x_right_s;
                  dir_x_s  = x_over_s;
               end else if (rally_s) begin
                  ball_x_s       = x_hit_s;
                  dir_x_s        = 1'b0;
                  win_s          = sat_inc(win_r);
                  result_valid_s = 1'b1;
                  game_result_s  = 1'b1;
               end else begin
                  ball_x_s = x_left_s;
               end
               if (dir_y_r) begin
                  ball_y_s = y_up_s;
                  dir_y_s  = !y_top_s;
               end else begin
                  ball_y_s = y_dn_s;
                  dir_y_s  = y_bot_s;
               end
               case (paddle_control)
                  2'b10:   paddle_s = p_up_s;
                  2'b01:   paddle_s = p_dn_s;
                  default: paddle_s = paddle_r;
               endcase
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_RESULT: begin
            if (game_end_valid) begin
               state_s = ST_WAIT;
            end else if (game_start_valid) begin
               state_s  = ST_RUN;
               ball_x_s = X_CTR_C;
               ball_y_s = Y_CTR_C;
               paddle_s = PAD_RST_C;
               dir_x_s  = serve_dx_s;
               dir_y_s  = serve_dy_s;
            end else begin
               state_s = ST_RESULT;
            end
         end
         default: begin
            state_s = ST_WAIT;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_WAIT;
         ball_x_r       <= X_CTR_C;
         ball_y_r       <= Y_CTR_C;
         paddle_r       <= PAD_RST_C;
         dir_x_r        <= 1'b0;
         dir_y_r        <= 1'b0;
         win_r          <= CNT_ZERO_C;
         lose_r         <= CNT_ZERO_C;
         result_valid_r <= 1'b0;
         game_result_r  <= 1'b0;
      end else begin
         state_r        <= state_s;
         ball_x_r       <= ball_x_s;
         ball_y_r       <= ball_y_s;
         paddle_r       <= paddle_s;
         dir_x_r        <= dir_x_s;
         dir_y_r        <= dir_y_s;
         win_r          <= win_s;
         lose_r         <= lose_s;
         result_valid_r <= result_valid_s;
         game_result_r  <= game_result_s;
      end
   end

   assign game_start_ready = (state_r == ST_WAIT) || (state_r == ST_RESULT);
   assign game_end_ready   = (state_r == ST_RUN) || (state_r == ST_RESULT);
   assign result_valid     = result_valid_r;
   assign game_result      = game_result_r;
   assign ball_x           = ball_x_r;
   assign ball_y           = ball_y_r;
   assign paddle_pos       = paddle_r;
   assign ball_dir_x       = dir_x_r;
   assign ball_dir_y       = dir_y_r;
   assign win_counter      = win_r;
   assign lose_counter     = lose_r;

endmodule

// File: tb/tb_pong_engine_v2.sv
// Randomised and directed bench for pong_engine_v2 against an integer game model.
module tb_pong_engine_v2;

   localparam int BW = 40, BH = 16, VX = 1, VY = 1, PL = 2, PV = 1, CMAX = 255;
   localparam int M_WAIT = 0, M_RUN = 1, M_RESULT = 2;

   logic       clk = 1'b0;
   logic       reset, game_start_valid, game_end_valid, step_en;
   logic [1:0] paddle_control;
   logic       game_start_ready, game_end_ready, result_valid, game_result;
   logic       ball_dir_x, ball_dir_y;
   logic [7:0] ball_x, ball_y, paddle_pos, win_counter, lose_counter;

   int errors = 0;
   int checks = 0;
   int m_mode, mx, my, mp, mdx, mdy, mwin, mlose, mrv, mgr, mlfsr;

   always #5 clk = ~clk;

   pong_engine_v2 dut (
      .clk(clk), .reset(reset),
      .game_start_valid(game_start_valid), .game_start_ready(game_start_ready),
      .game_end_valid(game_end_valid), .game_end_ready(game_end_ready),
      .step_en(step_en), .paddle_control(paddle_control),
      .result_valid(result_valid), .game_result(game_result),
      .ball_x(ball_x), .ball_y(ball_y), .paddle_pos(paddle_pos),
      .ball_dir_x(ball_dir_x), .ball_dir_y(ball_dir_y),
      .win_counter(win_counter), .lose_counter(lose_counter)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_serve();
      mx = BW / 2;
      my = BH / 2;
      mp = BH / 2 + PL / 2;
`ifdef PONG_SERVE_RAND_EN
      mdx = (mlfsr >> 1) & 1;
      mdy = mlfsr & 1;
`else
      mdx = 0;
      mdy = 0;
`endif
   endtask

   task automatic model_reset();
      m_mode = M_WAIT;
      mx = BW / 2; my = BH / 2; mp = BH / 2 + PL / 2;
      mdx = 0; mdy = 0; mwin = 0; mlose = 0; mrv = 0; mgr = 0;
      mlfsr = 8'hA5;
   endtask

   task automatic model_step(input logic [1:0] pc);
      int nx, ny, np, ndx, ndy;
      nx = mx; ny = my; np = mp; ndx = mdx; ndy = mdy;
      if (mdx == 1 && mx < VX) begin
         mrv = 1;
         mgr = (mp - PL <= my && my <= mp) ? 1 : 0;
         if (mgr == 0) begin
            if (mlose < CMAX) mlose++;
            m_mode = M_RESULT;
            return;
         end
         if (mwin < CMAX) mwin++;
         nx = VX - mx;
         ndx = 0;
      end else if (mdx == 0) begin
         if (mx + VX > BW) begin nx = 2 * BW - VX - mx; ndx = 1; end
         else nx = mx + VX;
      end else begin
         nx = mx - VX;
      end
      if (mdy == 1) begin
         if (my + VY > BH) begin ny = 2 * BH - VY - my; ndy = 0; end
         else ny = my + VY;
      end else begin
         if (my < VY) begin ny = VY - my; ndy = 1; end
         else ny = my - VY;
      end
      if (pc == 2'b10) np = (mp + PV > BH) ? BH : mp + PV;
      else if (pc == 2'b01) np = (mp - PV < PL) ? PL : mp - PV;
      mx = nx; my = ny; mp = np; mdx = ndx; mdy = ndy;
   endtask

   task automatic model_clock(input logic r, input logic s, input logic e, input logic st,
                              input logic [1:0] pc);
      int fb;
      if (r) begin
         model_reset();
         return;
      end
      mrv = 0;
      if (m_mode == M_WAIT) begin
         if (s) begin model_serve(); mwin = 0; mlose = 0; m_mode = M_RUN; end
      end else if (m_mode == M_RUN) begin
         if (e) m_mode = M_WAIT;
         else if (st) model_step(pc);
      end else begin
         if (e) m_mode = M_WAIT;
         else if (s) begin model_serve(); m_mode = M_RUN; end
      end
      fb = ((mlfsr >> 7) ^ (mlfsr >> 5) ^ (mlfsr >> 4) ^ (mlfsr >> 3)) & 1;
      mlfsr = ((mlfsr << 1) | fb) & 255;
   endtask

   task automatic compare_all();
      check("ball_x", ball_x, mx);
      check("ball_y", ball_y, my);
      check("paddle_pos", paddle_pos, mp);
      check("ball_dir_x", ball_dir_x, mdx);
      check("ball_dir_y", ball_dir_y, mdy);
      check("win_counter", win_counter, mwin);
      check("lose_counter", lose_counter, mlose);
      check("result_valid", result_valid, mrv);
      check("start_ready", game_start_ready, (m_mode != M_RUN) ? 1 : 0);
      check("end_ready", game_end_ready, (m_mode != M_WAIT) ? 1 : 0);
      if (mrv == 1) check("game_result", game_result, mgr);
   endtask

   task automatic cycle(input logic r, input logic s, input logic e, input logic st,
                        input logic [1:0] pc);
      reset = r; game_start_valid = s; game_end_valid = e; step_en = st; paddle_control = pc;
      model_clock(r, s, e, st, pc);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic restart();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
   endtask

   initial begin
      reset = 1'b1; game_start_valid = 1'b0; game_end_valid = 1'b0;
      step_en = 1'b0; paddle_control = 2'b00;
      model_reset();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      check("rst_paddle", paddle_pos, 9);
      check("rst_ball_y", ball_y, 8);

      // one step after a start
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      check("t1_x", ball_x, 21);
      check("t1_y", ball_y, 7);
      check("t1_start_rdy", game_start_ready, 0);
      check("t1_end_rdy", game_end_ready, 1);

      // full traverse ending in a miss
      restart();
      for (int i = 1; i <= 61; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
         if (i == 20) check("t2_x20", ball_x, 40);
         if (i == 60) begin check("t2_x60", ball_x, 0); check("t2_y60", ball_y, 12); end
      end
      check("t2_rv", result_valid, 1);
      check("t2_gr", game_result, 0);
      check("t2_lose", lose_counter, 1);
      check("t2_result_state", game_start_ready, 1);

      // same traverse with the paddle raised: hit
      restart();
      for (int i = 1; i <= 61; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1, (i <= 3) ? 2'b10 : 2'b00);
         if (i == 3) check("t3_paddle", paddle_pos, 12);
      end
      check("t3_rv", result_valid, 1);
      check("t3_gr", game_result, 1);
      check("t3_win", win_counter, 1);
      check("t3_x", ball_x, 1);
      check("t3_run", game_start_ready, 0);

      // paddle clamps
      restart();
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
      check("t4_top", paddle_pos, 16);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
      check("t4_bot", paddle_pos, 2);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
      check("t4_hold", paddle_pos, 2);

      // start and end together in RESULT: end wins, counters held
      restart();
      for (int i = 0; i < 61; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
      check("t5_wait", game_end_ready, 0);
      check("t5_lose_held", lose_counter, 1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      check("t5_lose_clr", lose_counter, 0);
      check("t5_x", ball_x, 20);
      check("t5_y", ball_y, 8);

      // reset in the middle of a run
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      check("t6_x", ball_x, 20);
      check("t6_paddle", paddle_pos, 9);
      check("t6_wait", game_end_ready, 0);

      // randomised traffic
      for (int i = 0; i < 5000; i++) begin
         cycle(($urandom_range(499) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(7) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(199) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
               2'($urandom_range(3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
